computer: RTL and testbench

COMPUTER -- requirements
Module: computer

---
 rtl/computer.sv | 138 +++++++++++++
 tb/tb_computer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/computer.sv
// computer: single-cycle 8-bit accumulator machine with a 256 x 16-bit instruction ROM.
//
// Ports (top module computer):
//   clk          in   1  single clock, all state updates on the rising edge
//   rst_n        in   1  synchronous active-low reset (clears pc, regA, regB)
//   alu_out_bus  out  8  combinational ALU result of the instruction at pc
//
// Instruction word: [15] LA, [14] LB, [13] SA, [12:11] SB, [10:8] S, [7:0] K.
// Probe points: PC.pc, IM.mem, pc_out_bus, im_out_bus, regA_out_bus, regB_out_bus.
//
// Build option: define COMPUTER_HALT_EN to make 16'hFFFF a HALT instruction that freezes
// pc and both registers until reset. Without it, 16'hFFFF executes as an ordinary instruction.

// Program counter: increments whenever enabled, wraps 8'hFF -> 8'h00 naturally.
module computer_pc (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  output logic [7:0] pc_o
);
  logic [7:0] pc;
  logic [7:0] pc_d;

  always_comb begin
    pc_d = pc;
    if (en_i) pc_d = pc + 8'd1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) pc <= 8'h00;
    else         pc <= pc_d;
  end

  assign pc_o = pc;
endmodule

// Instruction ROM, asynchronous read. Contents are loaded from outside the design;
// nothing in the design ever writes mem.
module computer_im (
  input  logic [7:0]  addr_i,
  output logic [15:0] data_o
);
  logic [15:0] mem [0:255];

  assign data_o = mem[addr_i];
endmodule

module computer (
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] alu_out_bus
);
  logic [7:0]  pc_out_bus;
  logic [15:0] im_out_bus;
  logic [7:0]  regA_out_bus;
  logic [7:0]  regB_out_bus;

  logic [7:0]  reg_a_q, reg_a_d;
  logic [7:0]  reg_b_q, reg_b_d;
  logic        halt;
  logic        la, lb, sa;
  logic [1:0]  sb;
  logic [2:0]  op;
  logic [7:0]  lit;
  logic [7:0]  op_a, op_b;

  computer_pc PC (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (~halt),
    .pc_o   (pc_out_bus)
  );

  computer_im IM (
    .addr_i (pc_out_bus),
    .data_o (im_out_bus)
  );

  assign la  = im_out_bus[15];
  assign lb  = im_out_bus[14];
  assign sa  = im_out_bus[13];
  assign sb  = im_out_bus[12:11];
  assign op  = im_out_bus[10:8];
  assign lit = im_out_bus[7:0];

`ifdef COMPUTER_HALT_EN
  assign halt = (im_out_bus == 16'hFFFF);
`else
  assign halt = 1'b0;
`endif

  // Operand selection.
  always_comb begin
    op_a = sa ? 8'h00 : reg_a_q;
    case (sb)
      2'b00:   op_b = reg_b_q;
      2'b01:   op_b = lit;
      default: op_b = 8'h00;
    endcase
  end

  // ALU: every result is 8 bits wide, so carries and shifted-out bits are simply dropped.
  always_comb begin
    case (op)
      3'b000:  alu_out_bus = op_a + op_b;
      3'b001:  alu_out_bus = op_a - op_b;
      3'b010:  alu_out_bus = op_a & op_b;
      3'b011:  alu_out_bus = op_a | op_b;
      3'b100:  alu_out_bus = op_a ^ op_b;
      3'b101:  alu_out_bus = ~op_a;
      3'b110:  alu_out_bus = op_a << 1;
      default: alu_out_bus = op_a >> 1;
    endcase
  end

  // Register next state; LA and LB together load the same ALU value into both.
  always_comb begin
    reg_a_d = reg_a_q;
    reg_b_d = reg_b_q;
    if (!halt) begin
      if (la) reg_a_d = alu_out_bus;
      if (lb) reg_b_d = alu_out_bus;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_a_q <= 8'h00;
      reg_b_q <= 8'h00;
    end else begin
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
    end
  end

  assign regA_out_bus = reg_a_q;
  assign regB_out_bus = reg_b_q;
endmodule

// File: tb/tb_computer.sv
// Self-checking bench for computer. A reference model tracks pc/regA/regB; every clock edge
// pushes the model's expected post-edge state onto a scoreboard queue, and each test task pops
// and compares it against the DUT. The ALU output is checked against the model before edges.
module tb_computer;
  logic       clk;
  logic       rst_n;
  logic [7:0] alu_out_bus;

  computer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_out_bus (alu_out_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] a;
    logic [7:0] b;
  } state_t;

  state_t      sb_q[$];
  logic [15:0] m_mem [0:255];
  logic [7:0]  m_pc, m_a, m_b;
  int          errors = 0;
  int          checks = 0;

`ifdef COMPUTER_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  function automatic logic [7:0] ref_alu(input logic [15:0] ins, input logic [7:0] ra,
                                         input logic [7:0] rb);
    logic [7:0] a, b;
    a = ins[13] ? 8'h00 : ra;
    if (ins[12:11] == 2'b00)      b = rb;
    else if (ins[12:11] == 2'b01) b = ins[7:0];
    else                          b = 8'h00;
    case (ins[10:8])
      3'd0: return 8'(a + b);
      3'd1: return 8'(a - b);
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {a[6:0], 1'b0};
      default: return {1'b0, a[7:1]};
    endcase
  endfunction

  task automatic load(input int idx, input logic [15:0] val);
    dut.IM.mem[idx] = val;
    m_mem[idx] = val;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) load(i, 16'h0000);
  endtask

  // Advance the model by one edge, push its expectation, then clock the DUT.
  task automatic clock_edge();
    logic [7:0]  r;
    logic [15:0] ins;
    state_t      e;
    ins = m_mem[m_pc];
    if (!rst_n) begin
      m_pc = 8'h00; m_a = 8'h00; m_b = 8'h00;
    end else if (!(HaltEn && ins == 16'hFFFF)) begin
      r = ref_alu(ins, m_a, m_b);
      if (ins[15]) m_a = r;
      if (ins[14]) m_b = r;
      m_pc = m_pc + 8'd1;
    end
    e = '{pc: m_pc, a: m_a, b: m_b};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clock_edge();
    void'(sb_q.pop_front());
    rst_n = 1'b1;
  endtask

  task automatic load_demo();
    clear_mem();
    load(0, 16'hA805);
    load(1, 16'h4803);
    load(2, 16'h8100);
    load(3, 16'hC600);
  endtask

  task automatic test_reset();
    state_t e, o;
    load_demo();
    m_pc = 8'h5A; m_a = 8'h33; m_b = 8'h44;
    rst_n = 1'b0;
    clock_edge();
    e = sb_q.pop_front();
    o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
    checks++;
    if (o !== e || o !== 24'h0) begin
      errors++;
      $display("FAIL reset_state: got pc/a/b=%h want %h", o, e);
    end
    checks++;
    if (alu_out_bus !== 8'h05) begin
      errors++;
      $display("FAIL reset_alu: got %h want 05", alu_out_bus);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_program();
    state_t     e, o;
    logic [7:0] want_alu;
    for (int i = 0; i < 4; i++) begin
      want_alu = ref_alu(m_mem[m_pc], m_a, m_b);
      checks++;
      if (alu_out_bus !== want_alu) begin
        errors++;
        $display("FAIL prog_alu[%0d]: got %h want %h", i, alu_out_bus, want_alu);
      end
      if (i == 3) begin
        checks++;
        if (alu_out_bus !== 8'hFA) begin
          errors++;
          $display("FAIL prog_shl_alu: got %h want fa", alu_out_bus);
        end
      end
      clock_edge();
      e = sb_q.pop_front();
      o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL prog_state[%0d]: got pc/a/b=%h want %h", i, o, e);
      end
    end
    // Absolute values from the worked example: after 4 edges pc=4, regA=regB=FA.
    o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
    checks++;
    if (o !== 24'h04FAFA) begin
      errors++;
      $display("FAIL prog_final: got pc/a/b=%h want 04fafa", o);
    end
  endtask

  task automatic test_reset_mid();
    state_t e, o;
    load_demo();
    do_reset();
    clock_edge(); void'(sb_q.pop_front());
    clock_edge(); void'(sb_q.pop_front());
    rst_n = 1'b0;
    clock_edge();
    e = sb_q.pop_front();
    o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
    checks++;
    if (o !== e || o !== 24'h0) begin
      errors++;
      $display("FAIL mid_reset: got pc/a/b=%h want 000000", o);
    end
    rst_n = 1'b1;
    clock_edge();
    e = sb_q.pop_front();
    o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
    checks++;
    if (o !== e || o !== 24'h010500) begin
      errors++;
      $display("FAIL mid_restart: got pc/a/b=%h want 010500", o);
    end
  endtask

  task automatic test_halt_instr();
    state_t e, o;
    load_demo();
    load(3, 16'hFFFF);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      clock_edge();
      void'(sb_q.pop_front());
    end
    for (int i = 0; i < (HaltEn ? 10 : 1); i++) begin
      clock_edge();
      e = sb_q.pop_front();
      o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL ffff_state[%0d]: got pc/a/b=%h want %h", i, o, e);
      end
    end
    checks++;
    if (HaltEn ? (dut.PC.pc !== 8'h03) :
        ({dut.PC.pc, dut.regA_out_bus, dut.regB_out_bus} !== 24'h040000)) begin
      errors++;
      $display("FAIL ffff_final: got pc=%h a=%h b=%h", dut.PC.pc, dut.regA_out_bus,
               dut.regB_out_bus);
    end
  endtask

  task automatic test_wrap();
    state_t e, o;
    clear_mem();
    load(0, 16'hA805);
    load(1, 16'h4803);
    do_reset();
    for (int i = 0; i < 256; i++) begin
      clock_edge();
      e = sb_q.pop_front();
      if (i >= 253) begin
        o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
        checks++;
        if (o !== e) begin
          errors++;
          $display("FAIL wrap_state[%0d]: got pc/a/b=%h want %h", i, o, e);
        end
      end
    end
    o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
    checks++;
    if (o !== 24'h000508) begin
      errors++;
      $display("FAIL wrap_final: got pc/a/b=%h want 000508", o);
    end
  endtask

  task automatic test_random_ops();
    state_t     e, o;
    logic [7:0] want_alu;
    for (int i = 0; i < 256; i++) load(i, 16'($urandom()));
    do_reset();
    for (int i = 0; i < 300; i++) begin
      want_alu = ref_alu(m_mem[m_pc], m_a, m_b);
      checks++;
      if (alu_out_bus !== want_alu) begin
        errors++;
        $display("FAIL rand_alu[%0d]: got %h want %h", i, alu_out_bus, want_alu);
      end
      clock_edge();
      e = sb_q.pop_front();
      o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL rand_state[%0d]: got pc/a/b=%h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    state_t e, o;
    // Each instruction consumes the previous result: 7, 14, 28, 56 in both registers.
    clear_mem();
    load(0, 16'hE807);
    for (int i = 1; i < 4; i++) load(i, 16'hC600);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      clock_edge();
      e = sb_q.pop_front();
      o = '{pc: dut.PC.pc, a: dut.regA_out_bus, b: dut.regB_out_bus};
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b_state[%0d]: got pc/a/b=%h want %h", i, o, e);
      end
    end
    checks++;
    if (dut.regA_out_bus !== 8'h38 || dut.regB_out_bus !== 8'h38) begin
      errors++;
      $display("FAIL b2b_final: got a=%h b=%h want 38", dut.regA_out_bus, dut.regB_out_bus);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_program();
    test_reset_mid();
    test_halt_instr();
    test_back_to_back();
    test_wrap();
    test_random_ops();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
